// File: rtl/m_net_rx_frame_chk.sv
// Receive frame checker for a double-buffered frame store.
// Accepts a byte stream framed by i_rx_start / i_rx_end and writes the first NUM bytes
// into the bank not currently published. It then checks the sync header, the station
// address (own or broadcast), the length and the 16-bit additive checksum.
// A good frame flips the published bank (o_rd_bank). A bad frame leaves it untouched.
// Ports:
//   sys_clk, rst             clock, async active-high reset
//   i_rx_start               frame start pulse (aborts a frame in progress)
//   im_rx_data_p/i_rx_data_en_p  byte stream
//   i_rx_end                 end pulse, cycle after last byte
//   im_station_addr          own address matched against byte 2
//   o_wr_en/om_wr_addr/om_wr_data  buffer write port, addr = {bank, index}
//   o_rd_bank                bank holding latest good frame
//   o_frame_ok/o_frame_err   result pulses, om_err_code = {sum, len, addr, hdr}
//   om_ok_cnt/om_err_cnt     saturating frame counters
module m_net_rx_frame_chk #(
    parameter logic [7:0] NUM   = 8'd156,
    parameter logic [7:0] HEAD0 = 8'hEB,
    parameter logic [7:0] HEAD1 = 8'h90
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        i_rx_start,
    input  logic [7:0]  im_rx_data_p,
    input  logic        i_rx_data_en_p,
    input  logic        i_rx_end,
    input  logic [7:0]  im_station_addr,
    output logic        o_wr_en,
    output logic [8:0]  om_wr_addr,
    output logic [7:0]  om_wr_data,
    output logic        o_rd_bank,
    output logic        o_frame_ok,
    output logic        o_frame_err,
    output logic [3:0]  om_err_code,
    output logic [15:0] om_ok_cnt,
    output logic [15:0] om_err_cnt
);

    localparam logic [7:0]  SUM_HI   = NUM - 8'd2;
    localparam logic [7:0]  SUM_LO   = NUM - 8'd1;
    localparam logic [7:0]  IDX_MAX  = 8'hFF;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;
    localparam logic [3:0]  CODE_LEN = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Frame accumulation registers
    logic [7:0]  idx, idx_d;
    logic [15:0] sum, sum_d;
    logic [15:0] exp_sum, exp_sum_d;
    logic        hdr_flag, hdr_flag_d;
    logic        addr_flag, addr_flag_d;
    logic        len_flag, len_flag_d;

    // Next values of registered outputs
    logic        wr_en_d;
    logic [8:0]  wr_addr_d;
    logic [7:0]  wr_data_d;
    logic        rd_bank_d;
    logic        frame_ok_d;
    logic        frame_err_d;
    logic [3:0]  err_code_d;
    logic [15:0] ok_cnt_d;
    logic [15:0] err_cnt_d;

    // End-of-frame verdict
    logic        len_fin;
    logic        sum_fin;
    logic [3:0]  code_fin;

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start pulse always (re)enters RECV
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_rx_start) state_nxt = S_RECV;
            S_RECV:  begin
                if (i_rx_start)    state_nxt = S_RECV;
                else if (i_rx_end) state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = i_rx_start ? S_RECV : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The checksum counts only when the length is exactly right
    always_comb begin
        len_fin  = len_flag | (idx != NUM);
        sum_fin  = ~len_fin & (sum != exp_sum);
        code_fin = {sum_fin, len_fin, addr_flag, hdr_flag};
    end

    // Output and datapath next-value logic
    always_comb begin
        idx_d       = idx;
        sum_d       = sum;
        exp_sum_d   = exp_sum;
        hdr_flag_d  = hdr_flag;
        addr_flag_d = addr_flag;
        len_flag_d  = len_flag;
        wr_en_d     = 1'b0;
        wr_addr_d   = om_wr_addr;
        wr_data_d   = om_wr_data;
        rd_bank_d   = o_rd_bank;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = om_err_code;
        ok_cnt_d    = om_ok_cnt;
        err_cnt_d   = om_err_cnt;

        if (i_rx_start) begin
            idx_d       = 8'd0;
            sum_d       = 16'd0;
            exp_sum_d   = 16'd0;
            hdr_flag_d  = 1'b0;
            addr_flag_d = 1'b0;
            len_flag_d  = 1'b0;
        end

        if (state == S_RECV) begin
            if (i_rx_start) begin
                // Restart mid-frame: report the dropped frame as a length error
                frame_err_d = 1'b1;
                err_code_d  = CODE_LEN;
                if (om_err_cnt != CNT_MAX) err_cnt_d = om_err_cnt + 16'd1;
            end else if (i_rx_end) begin
                err_code_d = code_fin;
                if (code_fin == 4'h0) begin
                    frame_ok_d = 1'b1;
                    rd_bank_d  = ~o_rd_bank;
                    if (om_ok_cnt != CNT_MAX) ok_cnt_d = om_ok_cnt + 16'd1;
                end else begin
                    frame_err_d = 1'b1;
                    if (om_err_cnt != CNT_MAX) err_cnt_d = om_err_cnt + 16'd1;
                end
            end else if (i_rx_data_en_p) begin
                if (idx < NUM) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {~o_rd_bank, idx};
                    wr_data_d = im_rx_data_p;
                    if (idx < SUM_HI) sum_d = sum + 16'(im_rx_data_p);
                    if (idx == SUM_HI) exp_sum_d[15:8] = im_rx_data_p;
                    if (idx == SUM_LO) exp_sum_d[7:0]  = im_rx_data_p;
                    if (idx == 8'd0 && im_rx_data_p != HEAD0) hdr_flag_d = 1'b1;
                    if (idx == 8'd1 && im_rx_data_p != HEAD1) hdr_flag_d = 1'b1;
                    if (idx == 8'd2 && im_rx_data_p != im_station_addr
                                    && im_rx_data_p != 8'hFF) addr_flag_d = 1'b1;
                end else begin
                    len_flag_d = 1'b1;
                end
                if (idx != IDX_MAX) idx_d = idx + 8'd1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            idx         <= 8'd0;
            sum         <= 16'd0;
            exp_sum     <= 16'd0;
            hdr_flag    <= 1'b0;
            addr_flag   <= 1'b0;
            len_flag    <= 1'b0;
            o_wr_en     <= 1'b0;
            om_wr_addr  <= 9'd0;
            om_wr_data  <= 8'd0;
            o_rd_bank   <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            om_err_code <= 4'h0;
            om_ok_cnt   <= 16'd0;
            om_err_cnt  <= 16'd0;
        end else begin
            idx         <= idx_d;
            sum         <= sum_d;
            exp_sum     <= exp_sum_d;
            hdr_flag    <= hdr_flag_d;
            addr_flag   <= addr_flag_d;
            len_flag    <= len_flag_d;
            o_wr_en     <= wr_en_d;
            om_wr_addr  <= wr_addr_d;
            om_wr_data  <= wr_data_d;
            o_rd_bank   <= rd_bank_d;
            o_frame_ok  <= frame_ok_d;
            o_frame_err <= frame_err_d;
            om_err_code <= err_code_d;
            om_ok_cnt   <= ok_cnt_d;
            om_err_cnt  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_m_net_rx_frame_chk.sv
// Scoreboard bench for m_net_rx_frame_chk: stimulus pushes expected writes and frame
// verdicts; a negedge monitor pops and compares whenever the DUT strobes.
module tb_m_net_rx_frame_chk;

    localparam int unsigned NUM = 156;

    logic        sys_clk;
    logic        rst;
    logic        i_rx_start;
    logic [7:0]  im_rx_data_p;
    logic        i_rx_data_en_p;
    logic        i_rx_end;
    logic [7:0]  im_station_addr;
    logic        o_wr_en;
    logic [8:0]  om_wr_addr;
    logic [7:0]  om_wr_data;
    logic        o_rd_bank;
    logic        o_frame_ok;
    logic        o_frame_err;
    logic [3:0]  om_err_code;
    logic [15:0] om_ok_cnt;
    logic [15:0] om_err_cnt;

    m_net_rx_frame_chk dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .i_rx_start     (i_rx_start),
        .im_rx_data_p   (im_rx_data_p),
        .i_rx_data_en_p (i_rx_data_en_p),
        .i_rx_end       (i_rx_end),
        .im_station_addr(im_station_addr),
        .o_wr_en        (o_wr_en),
        .om_wr_addr     (om_wr_addr),
        .om_wr_data     (om_wr_data),
        .o_rd_bank      (o_rd_bank),
        .o_frame_ok     (o_frame_ok),
        .o_frame_err    (o_frame_err),
        .om_err_code    (om_err_code),
        .om_ok_cnt      (om_ok_cnt),
        .om_err_cnt     (om_err_cnt)
    );

    typedef struct packed {
        logic        ok;
        logic [3:0]  code;
        logic        bank;
        logic [15:0] okc;
        logic [15:0] errc;
    } res_t;

    logic [16:0] wq[$];
    res_t        rq[$];
    logic [7:0]  frm[$];

    int          checks = 0;
    int          errors = 0;

    logic        m_bank;
    logic [15:0] m_okc;
    logic [15:0] m_errc;
    bit          m_in_recv;

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (o_wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(om_wr_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [16:0] w;
                    w = wq.pop_front();
                    chk("wr_addr", 32'(om_wr_addr), 32'(w[16:8]));
                    chk("wr_data", 32'(om_wr_data), 32'(w[7:0]));
                end
            end
            if (o_frame_ok || o_frame_err) begin
                if (rq.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, o_frame_ok, o_frame_err}, 32'd0);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("frame_ok",  32'(o_frame_ok),  32'(r.ok));
                    chk("frame_err", 32'(o_frame_err), 32'(!r.ok));
                    chk("err_code",  32'(om_err_code), 32'(r.code));
                    chk("rd_bank",   32'(o_rd_bank),   32'(r.bank));
                    chk("ok_cnt",    32'(om_ok_cnt),   32'(r.okc));
                    chk("err_cnt",   32'(om_err_cnt),  32'(r.errc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reference verdict from the frame contents
    function automatic logic [3:0] exp_code(input logic [7:0] st);
        int n;
        int s;
        logic hdr, adr, len, cs;
        n   = frm.size();
        hdr = (n > 0 && frm[0] != 8'hEB) || (n > 1 && frm[1] != 8'h90);
        adr = (n > 2) && (frm[2] != st) && (frm[2] != 8'hFF);
        len = (n != NUM);
        cs  = 1'b0;
        if (n == NUM) begin
            s = 0;
            for (int i = 0; i < NUM - 2; i++) s += int'(frm[i]);
            cs = (s % 65536) != (int'(frm[NUM-2]) * 256 + int'(frm[NUM-1]));
        end
        return {cs, len, adr, hdr};
    endfunction

    task automatic build_good(input int n, input logic [7:0] st);
        int s;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
        if (n > 0) frm[0] = 8'hEB;
        if (n > 1) frm[1] = 8'h90;
        if (n > 2) frm[2] = st;
        if (n >= NUM) begin
            s = 0;
            for (int i = 0; i < NUM - 2; i++) s += int'(frm[i]);
            frm[NUM-2] = 8'((s / 256) % 256);
            frm[NUM-1] = 8'(s % 256);
        end
    endtask

    task automatic do_start();
        if (m_in_recv) begin
            m_errc = sat_inc(m_errc);
            rq.push_back({1'b0, 4'b0100, m_bank, m_okc, m_errc});
        end
        m_in_recv  = 1'b1;
        i_rx_start = 1'b1;
        tick();
        i_rx_start = 1'b0;
    endtask

    task automatic send_bytes(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            i_rx_data_en_p = 1'b1;
            im_rx_data_p   = frm[i];
            if (i < NUM) wq.push_back({~m_bank, 8'(i), frm[i]});
            tick();
            i_rx_data_en_p = 1'b0;
        end
    endtask

    task automatic do_end(input bit poke_check);
        logic [3:0] c;
        c = exp_code(im_station_addr);
        if (c == 4'h0) begin
            m_bank = ~m_bank;
            m_okc  = sat_inc(m_okc);
        end else begin
            m_errc = sat_inc(m_errc);
        end
        rq.push_back({(c == 4'h0), c, m_bank, m_okc, m_errc});
        m_in_recv = 1'b0;
        i_rx_end  = 1'b1;
        tick();
        i_rx_end  = 1'b0;
        if (poke_check) begin
            // Bytes and end in CHECK must be ignored
            i_rx_data_en_p = 1'b1;
            i_rx_end       = 1'b1;
            tick();
            i_rx_data_en_p = 1'b0;
            i_rx_end       = 1'b0;
        end
    endtask

    task automatic send_frame(input int gap);
        do_start();
        if (frm.size() > 0) send_bytes(0, frm.size() - 1);
        do_end(1'b0);
        repeat (gap) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"},   32'(o_wr_en),     32'd0);
        chk({tag, "_wr_addr"}, 32'(om_wr_addr),  32'd0);
        chk({tag, "_wr_data"}, 32'(om_wr_data),  32'd0);
        chk({tag, "_rd_bank"}, 32'(o_rd_bank),   32'd0);
        chk({tag, "_ok"},      32'(o_frame_ok),  32'd0);
        chk({tag, "_err"},     32'(o_frame_err), 32'd0);
        chk({tag, "_code"},    32'(om_err_code), 32'd0);
        chk({tag, "_ok_cnt"},  32'(om_ok_cnt),   32'd0);
        chk({tag, "_err_cnt"}, 32'(om_err_cnt),  32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        i_rx_start      = 1'b0;
        im_rx_data_p    = 8'h00;
        i_rx_data_en_p  = 1'b0;
        i_rx_end        = 1'b0;
        im_station_addr = 8'h05;
        m_bank          = 1'b0;
        m_okc           = 16'd0;
        m_errc          = 16'd0;
        m_in_recv       = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Good frame, then corrupted checksum byte
        build_good(NUM, 8'h05);
        send_frame(2);
        chk("good_bank", 32'(o_rd_bank), 32'd1);
        build_good(NUM, 8'h05);
        frm[154] = frm[154] ^ 8'h01;
        send_frame(2);

        // Short frame with bad header, long frame
        build_good(150, 8'h05);
        frm[0] = 8'h00;
        send_frame(1);
        build_good(160, 8'h05);
        send_frame(1);

        // Broadcast accepted, foreign address rejected
        build_good(NUM, 8'hFF);
        send_frame(1);
        build_good(NUM, 8'h06);
        send_frame(1);

        // Stray bytes/end in IDLE
        i_rx_data_en_p = 1'b1;
        i_rx_end       = 1'b1;
        repeat (3) tick();
        i_rx_data_en_p = 1'b0;
        i_rx_end       = 1'b0;
        tick();

        // Abort at byte 80 followed by a good frame
        build_good(NUM, 8'h05);
        do_start();
        send_bytes(0, 79);
        send_frame(2);

        // Stray bytes during CHECK, then back-to-back frames (start during CHECK)
        build_good(NUM, 8'h05);
        do_start();
        send_bytes(0, NUM - 1);
        do_end(1'b1);
        build_good(NUM, 8'h05);
        send_frame(0);
        build_good(NUM, 8'h05);
        send_frame(0);
        tick();

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            int n;
            int kind;
            im_station_addr = 8'($urandom_range(0, 254));
            n = ($urandom_range(0, 9) < 7) ? int'(NUM) : int'($urandom_range(140, 170));
            build_good(n, im_station_addr);
            kind = int'($urandom_range(0, 4));
            case (kind)
                1: frm[0] = frm[0] ^ 8'($urandom_range(1, 255));
                2: frm[1] = frm[1] ^ 8'($urandom_range(1, 255));
                3: frm[2] = ($urandom_range(0, 1) == 0) ? 8'hFF : im_station_addr + 8'd1;
                4: begin
                    int p;
                    p = int'($urandom_range(3, n - 1));
                    frm[p] = frm[p] ^ 8'($urandom_range(1, 255));
                end
                default: ;
            endcase
            send_frame(int'($urandom_range(0, 2)));
        end
        im_station_addr = 8'h05;
        repeat (3) tick();

        // Error counter saturation through repeated restarts
        for (int k = 0; k < 65540; k++) do_start();
        chk("err_cnt_sat", 32'(om_err_cnt), 32'hFFFF);
        build_good(NUM, 8'h05);
        send_frame(2);
        chk("err_cnt_hold", 32'(om_err_cnt), 32'hFFFF);

        // Reset in the middle of a frame
        build_good(NUM, 8'h05);
        do_start();
        send_bytes(0, 49);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst       = 1'b0;
        m_bank    = 1'b0;
        m_okc     = 16'd0;
        m_errc    = 16'd0;
        m_in_recv = 1'b0;
        repeat (5) tick();
        check_reset_outputs("postrst");

        // Recovery after reset
        build_good(NUM, 8'h05);
        send_frame(3);

        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_net_rx_frame_chk.md
M_NET_RX_FRAME_CHK -- requirements
Module: M_NET_rx_frame_chk

Interface
REQ-001 SHALL have parameter NUM, default 8'd156, frame length in bytes (excluding lead code).
REQ-002 SHALL have parameter HEAD0, default 8'hEB, first sync byte.
REQ-003 SHALL have parameter HEAD1, default 8'h90, second sync byte.
REQ-004 sys_clk  input  1  system clock, 50 MHz; one clock, all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_rx_start  input  1  one-cycle pulse, frame receive start.
REQ-007 im_rx_data_p  input  8  receive data byte.
REQ-008 i_rx_data_en_p  input  1  receive byte valid.
REQ-009 i_rx_end  input  1  one-cycle pulse, the cycle after the last valid byte.
REQ-010 im_station_addr  input  8  own station address, compared against byte 2.
REQ-011 o_wr_en  output  1  buffer write strobe.
REQ-012 om_wr_addr  output  9  buffer write address: {bank, byte index}.
REQ-013 om_wr_data  output  8  buffer write data.
REQ-014 o_rd_bank  output  1  bank holding the most recent good frame.
REQ-015 o_frame_ok  output  1  one-cycle pulse, good frame committed.
REQ-016 o_frame_err  output  1  one-cycle pulse, frame rejected.
REQ-017 om_err_code  output  4  error flags: [0] header, [1] address, [2] length, [3] checksum.
REQ-018 om_ok_cnt  output  16  good-frame counter.
REQ-019 om_err_cnt  output  16  rejected-frame counter.

Function
REQ-020 SHALL implement FSM IDLE -> RECV (on i_rx_start) -> CHECK (on i_rx_end) -> IDLE (one cycle later).
REQ-021 In RECV, each i_rx_data_en_p byte SHALL increment the 8-bit byte index, starting at 0.
REQ-022 Bytes with index < NUM SHALL be written registered: o_wr_en=1, om_wr_addr={~o_rd_bank, index}, om_wr_data=byte, one cycle after input.
REQ-023 Bytes with index >= NUM SHALL NOT be written; the index SHALL saturate at 255 and set the length flag.
REQ-024 Checksum: 16-bit sum modulo 2^16 of bytes 0..NUM-3; byte NUM-2 is the high byte and byte NUM-1 the low byte of the expected sum.
REQ-025 Flags: header if byte0!=HEAD0 or byte1!=HEAD1; address if byte2 is neither im_station_addr nor 8'hFF (broadcast); length if byte count != NUM at i_rx_end; checksum if mismatch (evaluated only if count==NUM; otherwise 0).
REQ-026 In CHECK, if all flags are 0: o_frame_ok=1, o_rd_bank toggles, om_ok_cnt+1; otherwise o_frame_err=1, om_err_cnt+1, o_rd_bank unchanged.
REQ-027 o_frame_ok/o_frame_err SHALL assert exactly on the cycle after i_rx_end, one cycle wide, mutually exclusive.
REQ-028 om_err_code SHALL update on the same cycle and hold until the next CHECK; it is 4'h0 on a good frame.
REQ-029 Counters SHALL saturate at 16'hFFFF.
REQ-030 i_rx_start in RECV SHALL abort the frame: o_frame_err pulse next cycle with om_err_code=4'b0100, om_err_cnt+1, index cleared, stay in RECV for the new frame.
REQ-031 i_rx_data_en_p or i_rx_end in IDLE/CHECK SHALL be ignored.
REQ-032 i_rx_start coincident with CHECK SHALL enter RECV next cycle without losing the CHECK result.
REQ-033 Writes to bank ~o_rd_bank SHALL never alter the bank currently indicated by o_rd_bank.

Reset
REQ-034 On rst: FSM=IDLE; index, sum, flags cleared; o_wr_en=0, om_wr_addr=0, om_wr_data=0, o_rd_bank=0, o_frame_ok=0, o_frame_err=0, om_err_code=0, om_ok_cnt=0, om_err_cnt=0.
REQ-035 rst mid-frame SHALL discard the frame with no ok/err pulse after release.

Verification
REQ-036 Good 156-byte frame EB 90 addr=im_station_addr=8'h05, correct sum -> 156 writes to bank 1, o_frame_ok the cycle after i_rx_end, o_rd_bank=1, om_ok_cnt=1.
REQ-037 Same frame with byte 154 corrupted -> o_frame_err, om_err_code=4'b1000, o_rd_bank=0, om_err_cnt=1.
REQ-038 150-byte frame with byte0=8'h00 -> om_err_code=4'b0101; 160-byte frame -> exactly 156 writes, om_err_code=4'b0100.
REQ-039 Broadcast byte2=8'hFF -> accepted; byte2=8'h06 -> om_err_code=4'b0010.
REQ-040 i_rx_start at byte 80, then a good frame -> one err pulse (4'b0100), then one ok pulse; om_err_cnt=1, om_ok_cnt=1.
REQ-041 Preload om_ok_cnt=16'hFFFF via 65535 frames (or force) -> next good frame leaves 16'hFFFF; rst asserted at byte 50 -> no pulses, all outputs at reset values.
